// File: rtl/onehot_select_seq_if.sv
// Request/scan/output bundle for the one-hot write-select decoder.
interface onehot_select_seq_if #(
    parameter int unsigned SEL_W = 3
);
    localparam int unsigned OUT_W = 1 << SEL_W;

    logic             enable;
    logic             req_valid;
    logic [SEL_W-1:0] req_sel;
    logic             req_ready;
    logic             scan_start;
    logic             scan_busy;
    logic             scan_done;
    logic [OUT_W-1:0] out_onehot;
    logic             out_valid;
    logic [SEL_W-1:0] out_index;

    // Write-control side: issues requests and scans, consumes the select.
    modport master (
        output enable, req_valid, req_sel, scan_start,
        input  req_ready, scan_busy, scan_done, out_onehot, out_valid, out_index
    );

    // Decoder side.
    modport slave (
        input  enable, req_valid, req_sel, scan_start,
        output req_ready, scan_busy, scan_done, out_onehot, out_valid, out_index
    );
endinterface

// File: rtl/onehot_select_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder for register-file write selects.
// DIRECT mode decodes one accepted request per cycle; SCAN mode walks a single
// bit across every output (bulk clear/init). MASK_ZERO suppresses index 0 for a
// hardwired zero register.
module onehot_select_seq #(
    parameter int unsigned SEL_W     = 3,
    parameter bit          MASK_ZERO = 1'b0
) (
    input logic                clock,
    input logic                ctrl_reset_n,
    onehot_select_seq_if.slave bus
);
    localparam int unsigned      OUT_W = 1 << SEL_W;
    localparam logic [SEL_W-1:0] FIRST = MASK_ZERO ? SEL_W'(1) : SEL_W'(0);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(OUT_W - 1);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e           state_q;
    logic [SEL_W-1:0] cnt_q;
    logic [OUT_W-1:0] onehot_q;
    logic             valid_q;
    logic [SEL_W-1:0] index_q;
    logic             done_q;

    // Handshake and status derived from the current state.
    always_comb begin
        bus.req_ready = bus.enable & (state_q == StIdle) & ~bus.scan_start;
        bus.scan_busy = (state_q == StScan);
    end

    // Control FSM with registered decoder outputs; enable low freezes state/cnt.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            index_q  <= '0;
            done_q   <= 1'b0;
        end else if (!bus.enable) begin
            onehot_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.scan_start) begin
                        // Scan wins over a same-cycle request.
                        state_q  <= StScan;
                        cnt_q    <= FIRST;
                        onehot_q <= '0;
                        valid_q  <= 1'b0;
                    end else if (bus.req_valid) begin
                        if (MASK_ZERO && (bus.req_sel == '0)) begin
                            // Accepted but never drives the hardwired zero register.
                            onehot_q <= '0;
                            valid_q  <= 1'b0;
                            index_q  <= '0;
                        end else begin
                            onehot_q <= OUT_W'(1) << bus.req_sel;
                            valid_q  <= 1'b1;
                            index_q  <= bus.req_sel;
                        end
                    end else begin
                        onehot_q <= '0;
                        valid_q  <= 1'b0;
                    end
                end
                StScan: begin
                    onehot_q <= OUT_W'(1) << cnt_q;
                    valid_q  <= 1'b1;
                    index_q  <= cnt_q;
                    if (cnt_q == LAST) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        done_q <= 1'b0;
                        cnt_q  <= cnt_q + SEL_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.out_onehot = onehot_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_index  = index_q;
    assign bus.scan_done  = done_q;
endmodule

// File: tb/tb_onehot_select_seq.sv
// Directed bench for onehot_select_seq: one instance unmasked, one with MASK_ZERO.
module tb_onehot_select_seq;
    logic clock = 1'b0;
    logic ctrl_reset_n = 1'b0;

    always #5 clock = ~clock;

    onehot_select_seq_if #(.SEL_W(3)) bus0 ();
    onehot_select_seq_if #(.SEL_W(3)) bus1 ();

    onehot_select_seq #(.SEL_W(3), .MASK_ZERO(1'b0)) dut0 (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .bus          (bus0)
    );

    onehot_select_seq #(.SEL_W(3), .MASK_ZERO(1'b1)) dut1 (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .bus          (bus1)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       en;
        logic       vld;
        logic [2:0] sel;
        logic       rdy;
        logic       ov;
        logic [7:0] oh;
        logic [2:0] idx;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1 time unit later.
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out0(input string name, input logic v, input logic [7:0] oh,
                              input logic [2:0] idx, input logic done);
        check({name, ".valid"}, 32'(bus0.out_valid), 32'(v));
        check({name, ".onehot"}, 32'(bus0.out_onehot), 32'(oh));
        check({name, ".index"}, 32'(bus0.out_index), 32'(idx));
        check({name, ".done"}, 32'(bus0.scan_done), 32'(done));
    endtask

    task automatic check_out1(input string name, input logic v, input logic [7:0] oh,
                              input logic [2:0] idx, input logic done);
        check({name, ".valid"}, 32'(bus1.out_valid), 32'(v));
        check({name, ".onehot"}, 32'(bus1.out_onehot), 32'(oh));
        check({name, ".index"}, 32'(bus1.out_index), 32'(idx));
        check({name, ".done"}, 32'(bus1.scan_done), 32'(done));
    endtask

    initial begin
        logic [7:0] exp_oh;

        bus0.enable = 1'b1; bus0.req_valid = 1'b0; bus0.req_sel = '0; bus0.scan_start = 1'b0;
        bus1.enable = 1'b1; bus1.req_valid = 1'b0; bus1.req_sel = '0; bus1.scan_start = 1'b0;

        // Reset state.
        #12;
        check_out0("reset", 1'b0, 8'h00, 3'd0, 1'b0);
        check("reset.busy", 32'(bus0.scan_busy), 32'd0);
        check("reset.ready", 32'(bus0.req_ready), 32'd1);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        cycle();

        // Direct decode table: drive, check ready, clock, check outputs.
        vecs[0] = '{en: 1'b1, vld: 1'b1, sel: 3'd5, rdy: 1'b1, ov: 1'b1, oh: 8'h20, idx: 3'd5};
        vecs[1] = '{en: 1'b1, vld: 1'b1, sel: 3'd3, rdy: 1'b1, ov: 1'b1, oh: 8'h08, idx: 3'd3};
        vecs[2] = '{en: 1'b1, vld: 1'b1, sel: 3'd0, rdy: 1'b1, ov: 1'b1, oh: 8'h01, idx: 3'd0};
        vecs[3] = '{en: 1'b1, vld: 1'b0, sel: 3'd6, rdy: 1'b1, ov: 1'b0, oh: 8'h00, idx: 3'd0};
        vecs[4] = '{en: 1'b0, vld: 1'b1, sel: 3'd7, rdy: 1'b0, ov: 1'b0, oh: 8'h00, idx: 3'd0};
        vecs[5] = '{en: 1'b1, vld: 1'b1, sel: 3'd7, rdy: 1'b1, ov: 1'b1, oh: 8'h80, idx: 3'd7};
        vecs[6] = '{en: 1'b1, vld: 1'b1, sel: 3'd1, rdy: 1'b1, ov: 1'b1, oh: 8'h02, idx: 3'd1};
        vecs[7] = '{en: 1'b1, vld: 1'b0, sel: 3'd0, rdy: 1'b1, ov: 1'b0, oh: 8'h00, idx: 3'd1};
        for (int i = 0; i < 8; i++) begin
            bus0.enable = vecs[i].en;
            bus0.req_valid = vecs[i].vld;
            bus0.req_sel = vecs[i].sel;
            #1;
            check($sformatf("vec%0d.ready", i), 32'(bus0.req_ready), 32'(vecs[i].rdy));
            cycle();
            check_out0($sformatf("vec%0d", i), vecs[i].ov, vecs[i].oh, vecs[i].idx, 1'b0);
        end
        bus0.enable = 1'b1;

        // Collision: scan_start and req_valid(sel=4) together; scan wins.
        bus0.scan_start = 1'b1; bus0.req_valid = 1'b1; bus0.req_sel = 3'd4;
        #1;
        check("coll.ready", 32'(bus0.req_ready), 32'd0);
        cycle();
        bus0.scan_start = 1'b0;
        check_out0("coll.start", 1'b0, 8'h00, 3'd1, 1'b0);
        check("coll.busy", 32'(bus0.scan_busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            // A second scan_start mid-scan must be ignored.
            bus0.scan_start = (i == 3);
            #1;
            check($sformatf("scan%0d.ready", i), 32'(bus0.req_ready), 32'd0);
            check($sformatf("scan%0d.busy", i), 32'(bus0.scan_busy), 32'd1);
            cycle();
            bus0.scan_start = 1'b0;
            if (i == 7) bus0.req_valid = 1'b0;
            exp_oh = 8'd1 << i;
            check_out0($sformatf("scan%0d", i), 1'b1, exp_oh, 3'(i), i == 7);
        end
        check("scan.end.busy", 32'(bus0.scan_busy), 32'd0);
        check("scan.end.ready", 32'(bus0.req_ready), 32'd1);
        cycle();
        check_out0("scan.after", 1'b0, 8'h00, 3'd7, 1'b0);

        // Stall for 3 cycles after beat 2; scan must resume at 3.
        bus0.scan_start = 1'b1;
        cycle();
        bus0.scan_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            exp_oh = 8'd1 << i;
            check_out0($sformatf("stall.pre%0d", i), 1'b1, exp_oh, 3'(i), 1'b0);
        end
        bus0.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d.ready", i), 32'(bus0.req_ready), 32'd0);
            cycle();
            check_out0($sformatf("stall%0d", i), 1'b0, 8'h00, 3'd2, 1'b0);
            check($sformatf("stall%0d.busy", i), 32'(bus0.scan_busy), 32'd1);
        end
        bus0.enable = 1'b1;
        for (int i = 3; i < 8; i++) begin
            cycle();
            exp_oh = 8'd1 << i;
            check_out0($sformatf("stall.post%0d", i), 1'b1, exp_oh, 3'(i), i == 7);
        end
        cycle();
        check("stall.done.clear", 32'(bus0.scan_done), 32'd0);

        // MASK_ZERO: request for 0 is accepted but produces nothing.
        bus1.req_valid = 1'b1; bus1.req_sel = 3'd0;
        #1;
        check("mz.req0.ready", 32'(bus1.req_ready), 32'd1);
        cycle();
        bus1.req_sel = 3'd2;
        check_out1("mz.req0", 1'b0, 8'h00, 3'd0, 1'b0);
        cycle();
        bus1.req_valid = 1'b0;
        check_out1("mz.req2", 1'b1, 8'h04, 3'd2, 1'b0);
        bus1.scan_start = 1'b1;
        cycle();
        bus1.scan_start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            cycle();
            exp_oh = 8'd1 << i;
            check_out1($sformatf("mz.scan%0d", i), 1'b1, exp_oh, 3'(i), i == 7);
        end
        check("mz.end.busy", 32'(bus1.scan_busy), 32'd0);

        // Asynchronous reset mid-scan clears outputs without waiting for a clock.
        bus0.scan_start = 1'b1;
        cycle();
        bus0.scan_start = 1'b0;
        cycle();
        cycle();
        cycle();
        check_out0("prerst", 1'b1, 8'h04, 3'd2, 1'b0);
        ctrl_reset_n = 1'b0;
        #1;
        check_out0("rst.mid", 1'b0, 8'h00, 3'd0, 1'b0);
        check("rst.mid.busy", 32'(bus0.scan_busy), 32'd0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        cycle();
        cycle();
        check_out0("rst.after", 1'b0, 8'h00, 3'd0, 1'b0);
        check("rst.after.ready", 32'(bus0.req_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
